// File: rtl/cache_sa.sv
// +--------------------------------------------------------------------------+
// | cache_sa : set-associative cache data/tag bank, FIFO victim per set,     |
// |            request/response handshake and invalidate sweep               |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module cache_sa #(
  parameter  int INDEX_W = 8,
  parameter  int WORD_W  = 2,
  parameter  int TAG_W   = 5,
  parameter  int DATA_W  = 16,
  parameter  int WAYS    = 2,
  localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               inv_all,
  input  logic [INDEX_W-1:0] index,
  input  logic [WORD_W-1:0]  word,
  input  logic               comp,
  input  logic               write,
  input  logic [TAG_W-1:0]   tag_in,
  input  logic [DATA_W-1:0]  data_in,
  input  logic               valid_in,
  output logic               resp_valid,
  output logic               hit,
  output logic [WAY_W-1:0]   way_out,
  output logic               dirty,
  output logic               valid,
  output logic [TAG_W-1:0]   tag_out,
  output logic [DATA_W-1:0]  data_out
);

  localparam int SETS  = 1 << INDEX_W;
  localparam int WORDS = 1 << WORD_W;

  typedef enum logic [0:0] {
    ST_SWEEP = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  // Storage: valid/dirty/pointer are cleared by the sweep, tag/data never are
  logic [WAYS-1:0]   valid_mem [SETS];
  logic [WAYS-1:0]   dirty_mem [SETS];
  logic [WAY_W-1:0]  vptr_mem  [SETS];
  logic [TAG_W-1:0]  tag_mem   [SETS][WAYS];
  logic [DATA_W-1:0] data_mem  [SETS][WAYS][WORDS];

  state_t              state_q, state_d;
  logic [INDEX_W-1:0]  cnt_q, cnt_d;
  logic                resp_valid_q, resp_valid_d;
  logic                hit_q, hit_d;
  logic [WAY_W-1:0]    way_q, way_d;
  logic                dirty_q, dirty_d;
  logic                valid_q, valid_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [DATA_W-1:0]   data_q, data_d;

  logic                accept;
  logic                sweep_clr;
  logic                hit_found;
  logic [WAY_W-1:0]    hit_way;
  logic [WAY_W-1:0]    vptr;
  logic [WAY_W-1:0]    sel_way;
  logic [WAY_W-1:0]    ptr_next;
  logic                do_cwrite;
  logic                do_fill;

  assign req_ready  = (state_q == ST_IDLE);
  assign accept     = rst & req_valid & (state_q == ST_IDLE) & ~inv_all;
  assign sweep_clr  = rst & (state_q == ST_SWEEP);
  assign vptr       = vptr_mem[index];
  assign sel_way    = (comp & hit_found) ? hit_way : vptr;
  assign do_cwrite  = accept & comp & write & hit_found;
  assign do_fill    = accept & ~comp & write;
  assign ptr_next   = (WAYS == 1) ? '0 : vptr + WAY_W'(1);

  // Descending scan so the lowest-numbered matching way wins
  always_comb begin
    hit_found = 1'b0;
    hit_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_mem[index][w] && (tag_mem[index][w] == tag_in)) begin
        hit_found = 1'b1;
        hit_way   = WAY_W'(w);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sweep_clr) begin
      valid_mem[cnt_q] <= '0;
      dirty_mem[cnt_q] <= '0;
      vptr_mem[cnt_q]  <= '0;
    end
    if (do_cwrite) begin
      data_mem[index][hit_way][word] <= data_in;
      dirty_mem[index][hit_way]      <= 1'b1;
    end
    if (do_fill) begin
      tag_mem[index][vptr]        <= tag_in;
      data_mem[index][vptr][word] <= data_in;
      valid_mem[index][vptr]      <= valid_in;
      dirty_mem[index][vptr]      <= 1'b0;
      if (&word) begin
        vptr_mem[index] <= ptr_next;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    resp_valid_d = accept;
    hit_d        = hit_q;
    way_d        = way_q;
    dirty_d      = dirty_q;
    valid_d      = valid_q;
    tag_d        = tag_q;
    data_d       = data_q;

    case (state_q)
      ST_SWEEP: begin
        cnt_d = cnt_q + INDEX_W'(1);
        if (&cnt_q) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (inv_all) begin
          state_d = ST_SWEEP;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_SWEEP;
    endcase

    if (accept) begin
      hit_d = comp & hit_found;
      way_d = sel_way;
      if (comp) begin
        valid_d = valid_mem[index][sel_way];
        tag_d   = tag_mem[index][sel_way];
        dirty_d = dirty_mem[index][sel_way] | (write & hit_found);
        data_d  = (write & hit_found) ? data_in : data_mem[index][sel_way][word];
      end else if (write) begin
        valid_d = valid_in;
        dirty_d = 1'b0;
        tag_d   = tag_in;
        data_d  = data_in;
      end else begin
        valid_d = valid_mem[index][sel_way];
        tag_d   = tag_mem[index][sel_way];
        dirty_d = dirty_mem[index][sel_way];
        data_d  = data_mem[index][sel_way][word];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_SWEEP;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      hit_q        <= 1'b0;
      way_q        <= '0;
      dirty_q      <= 1'b0;
      valid_q      <= 1'b0;
      tag_q        <= '0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      hit_q        <= hit_d;
      way_q        <= way_d;
      dirty_q      <= dirty_d;
      valid_q      <= valid_d;
      tag_q        <= tag_d;
      data_q       <= data_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign hit        = hit_q;
  assign way_out    = way_q;
  assign dirty      = dirty_q;
  assign valid      = valid_q;
  assign tag_out    = tag_q;
  assign data_out   = data_q;

endmodule

`default_nettype wire

// File: tb/tb_cache_sa.sv
// +--------------------------------------------------------------------------+
// | tb_cache_sa : testbench for cache_sa with reference model and scoreboard |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_cache_sa;

  localparam int INDEX_W = 8;
  localparam int WORD_W  = 2;
  localparam int TAG_W   = 5;
  localparam int DATA_W  = 16;
  localparam int WAYS    = 2;
  localparam int WAY_W   = 1;
  localparam int SETS    = 256;
  localparam int WORDS   = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               req_valid = 1'b0;
  logic               req_ready;
  logic               inv_all = 1'b0;
  logic [INDEX_W-1:0] index = '0;
  logic [WORD_W-1:0]  word = '0;
  logic               comp = 1'b0;
  logic               write = 1'b0;
  logic [TAG_W-1:0]   tag_in = '0;
  logic [DATA_W-1:0]  data_in = '0;
  logic               valid_in = 1'b0;
  logic               resp_valid;
  logic               hit;
  logic [WAY_W-1:0]   way_out;
  logic               dirty;
  logic               valid;
  logic [TAG_W-1:0]   tag_out;
  logic [DATA_W-1:0]  data_out;

  always #5 clk = ~clk;

  cache_sa #(
    .INDEX_W(INDEX_W), .WORD_W(WORD_W), .TAG_W(TAG_W), .DATA_W(DATA_W), .WAYS(WAYS)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .inv_all(inv_all), .index(index), .word(word), .comp(comp), .write(write),
    .tag_in(tag_in), .data_in(data_in), .valid_in(valid_in),
    .resp_valid(resp_valid), .hit(hit), .way_out(way_out), .dirty(dirty),
    .valid(valid), .tag_out(tag_out), .data_out(data_out)
  );

  typedef struct {
    logic             hit;
    logic [WAY_W-1:0] way;
    logic             dirty;
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic             tag_chk;
    logic [DATA_W-1:0] data;
    logic             data_chk;
  } resp_t;

  resp_t exp_q[$];
  resp_t mon_e;
  int    total = 0;
  int    bad   = 0;
  logic  acc_flag = 1'b0;
  logic  exp_rv   = 1'b0;
  logic  mon_en   = 1'b0;

  // Reference model: what the bank holds, with "known" flags for never-written tag/data
  bit               m_valid [SETS][WAYS];
  bit               m_dirty [SETS][WAYS];
  int               m_ptr   [SETS];
  logic [TAG_W-1:0] m_tag   [SETS][WAYS];
  bit               m_tk    [SETS][WAYS];
  logic [DATA_W-1:0] m_data [SETS][WAYS][WORDS];
  bit               m_dk    [SETS][WAYS][WORDS];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < SETS; s++) begin
      m_ptr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
      end
    end
  endtask

  task automatic model_req(input int idx, input int wd, input bit cp, input bit wr,
                           input logic [TAG_W-1:0] tg, input logic [DATA_W-1:0] dt,
                           input bit vi);
    int    hw;
    int    sel;
    resp_t r;
    hw = -1;
    for (int w = 0; w < WAYS; w++)
      if (hw < 0 && m_valid[idx][w] && m_tag[idx][w] == tg) hw = w;
    if (cp) begin
      sel = (hw >= 0) ? hw : m_ptr[idx];
      if (wr && hw >= 0) begin
        m_data[idx][sel][wd] = dt;
        m_dk[idx][sel][wd]   = 1'b1;
        m_dirty[idx][sel]    = 1'b1;
      end
    end else begin
      sel = m_ptr[idx];
      if (wr) begin
        m_tag[idx][sel]      = tg;
        m_tk[idx][sel]       = 1'b1;
        m_valid[idx][sel]    = vi;
        m_dirty[idx][sel]    = 1'b0;
        m_data[idx][sel][wd] = dt;
        m_dk[idx][sel][wd]   = 1'b1;
        if (wd == WORDS - 1) m_ptr[idx] = (m_ptr[idx] + 1) % WAYS;
      end
    end
    r.hit      = cp && (hw >= 0);
    r.way      = sel[WAY_W-1:0];
    r.dirty    = m_dirty[idx][sel];
    r.valid    = m_valid[idx][sel];
    r.tag      = m_tag[idx][sel];
    r.tag_chk  = m_tk[idx][sel];
    r.data     = m_data[idx][sel][wd];
    r.data_chk = m_dk[idx][sel][wd];
    exp_q.push_back(r);
  endtask

  task automatic issue(input int idx, input int wd, input bit cp, input bit wr,
                       input logic [TAG_W-1:0] tg, input logic [DATA_W-1:0] dt,
                       input bit vi, input bit rv, input bit inv);
    @(posedge clk);
    #1;
    index     = idx[INDEX_W-1:0];
    word      = wd[WORD_W-1:0];
    comp      = cp;
    write     = wr;
    tag_in    = tg;
    data_in   = dt;
    valid_in  = vi;
    req_valid = rv;
    inv_all   = inv;
    acc_flag  = 1'b0;
    if (req_ready === 1'b1) begin
      if (inv) model_clear();
      else if (rv) begin
        model_req(idx, wd, cp, wr, tg, dt, vi);
        acc_flag = 1'b1;
      end
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    inv_all   = 1'b0;
    acc_flag  = 1'b0;
  endtask

  task automatic fill(input int idx, input logic [TAG_W-1:0] tg, input logic [DATA_W-1:0] base);
    for (int k = 0; k < WORDS; k++)
      issue(idx, k, 1'b0, 1'b1, tg, base * 16'(k + 1), 1'b1, 1'b1, 1'b0);
  endtask

  // Counts cycles with req_ready low, starting at the next falling edge
  task automatic count_low(input bit zero_chk);
    int n;
    n = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 1000) begin
      if (zero_chk)
        chk("sweep_outputs_zero",
            {resp_valid, hit, way_out, dirty, valid, tag_out, data_out}, 32'd0);
      n++;
      @(negedge clk);
    end
    chk("sweep_len", n, SETS);
  endtask

  always @(posedge clk) exp_rv <= acc_flag;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("resp_valid", resp_valid, exp_rv);
      if (resp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL resp_unexpected got=1 exp=0 at %0t", $time);
        end else begin
          mon_e = exp_q.pop_front();
          chk("hit", hit, mon_e.hit);
          chk("way_out", way_out, mon_e.way);
          chk("dirty", dirty, mon_e.dirty);
          chk("valid", valid, mon_e.valid);
          if (mon_e.tag_chk) chk("tag_out", tag_out, mon_e.tag);
          if (mon_e.data_chk) chk("data_out", data_out, mon_e.data);
        end
      end
    end
  end

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int idx;
    model_clear();
    // Reset and power-up sweep
    repeat (2) @(posedge clk);
    @(negedge clk);
    mon_en = 1'b1;
    chk("rst_ready", req_ready, 1'b0);
    chk("rst_outputs_zero",
        {resp_valid, hit, way_out, dirty, valid, tag_out, data_out}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    count_low(1'b1);

    issue(8'h00, 0, 1'b1, 1'b0, 5'h03, 16'h0, 1'b0, 1'b1, 1'b0);

    // Fill, hit, dirty-on-write, compare-write miss
    issue(8'h12, 0, 1'b0, 1'b1, 5'h0A, 16'h1111, 1'b1, 1'b1, 1'b0);
    issue(8'h12, 1, 1'b0, 1'b1, 5'h0A, 16'h2222, 1'b1, 1'b1, 1'b0);
    issue(8'h12, 2, 1'b0, 1'b1, 5'h0A, 16'h3333, 1'b1, 1'b1, 1'b0);
    issue(8'h12, 3, 1'b0, 1'b1, 5'h0A, 16'h4444, 1'b1, 1'b1, 1'b0);
    issue(8'h12, 2, 1'b1, 1'b0, 5'h0A, 16'h0, 1'b0, 1'b1, 1'b0);
    issue(8'h12, 1, 1'b1, 1'b1, 5'h0A, 16'hBEEF, 1'b0, 1'b1, 1'b0);
    issue(8'h12, 1, 1'b1, 1'b0, 5'h0A, 16'h0, 1'b0, 1'b1, 1'b0);
    issue(8'h12, 1, 1'b1, 1'b1, 5'h0B, 16'hDEAD, 1'b0, 1'b1, 1'b0);
    issue(8'h12, 1, 1'b1, 1'b0, 5'h0A, 16'h0, 1'b0, 1'b1, 1'b0);

    // Victim rotation and pointer wrap
    fill(8'h12, 5'h0B, 16'h0101);
    issue(8'h12, 1, 1'b0, 1'b0, 5'h00, 16'h0, 1'b0, 1'b1, 1'b0);
    issue(8'h12, 3, 1'b1, 1'b0, 5'h0B, 16'h0, 1'b0, 1'b1, 1'b0);
    idle();

    // Invalidate during back-to-back traffic; the colliding request is dropped
    for (int k = 0; k < 4; k++)
      issue(8'h12, k, 1'b1, 1'b0, 5'h0A, 16'h0, 1'b0, 1'b1, 1'b0);
    issue(8'h12, 0, 1'b1, 1'b0, 5'h0A, 16'h0, 1'b0, 1'b1, 1'b1);
    idle();
    count_low(1'b0);
    issue(8'h12, 2, 1'b1, 1'b0, 5'h0A, 16'h0, 1'b0, 1'b1, 1'b0);
    issue(8'h12, 0, 1'b0, 1'b0, 5'h00, 16'h0, 1'b0, 1'b1, 1'b0);

    // Randomized traffic over a few sets, including boundary sets 0x00 and 0xFF
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 3))
        0: idx = 8'h00;
        1: idx = 8'h12;
        2: idx = 8'h34;
        default: idx = 8'hFF;
      endcase
      issue(idx, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 16'($urandom), ($urandom_range(0, 7) != 0),
            ($urandom_range(0, 4) != 0), 1'b0);
    end
    idle();

    // Reset in the middle of an invalidate sweep restarts it from set 0
    issue(8'h00, 0, 1'b1, 1'b0, 5'h00, 16'h0, 1'b0, 1'b0, 1'b1);
    idle();
    repeat (99) @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    count_low(1'b1);
    for (int i = 0; i < 200; i++) begin
      idx = (i % 2 == 0) ? 8'h12 : 8'hFF;
      issue(idx, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 16'($urandom), 1'b1, 1'b1, 1'b0);
    end
    idle();

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
